iaoq_sequencer: RTL and testbench
=================================

# iaoq_sequencer

Next-address sequencer for the front half of the instruction address offset queue. It owns the IAOQ front register, which holds the fetch address, and computes the load value and load enable for the downstream IAOQ back register. It also implements PA-RISC delayed-branch redirection: a branch resolved while the pipe is stalled is parked in a one-entry pending buffer. It sits directly upstream of the IAOQ back stage and drives instruction memory.

## Interface
- WIDTH, 8, address width (byte address)
- INC, 4, sequential increment (one instruction)
- FRONT_RST, 0, front reset value; the back stage resets to FRONT_RST+INC = 4
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall; freezes both queue entries
- br_taken  in  1  branch resolved taken this cycle (single-cycle pulse)
- br_target  in  WIDTH  branch target; bits [1:0] ignored, forced to 00
- br_nullify  in  1  nullify the delay-slot instruction of this branch
- back_q  in  WIDTH  current IAOQ back register value
- iaoq_front  out  WIDTH  registered fetch address
- back_d  out  WIDTH  next value for the back register (combinational)
- back_le  out  1  load enable for the back register (combinational)
- slot_nullify  out  1  registered; the instruction at iaoq_front is nullified
- state  out  2  FSM state, for debug/verification

## Operation
- Registers: front, pend_valid, pend_target, pend_nullify, slot_nullify, state.
- Reset values: front=FRONT_RST, pend_valid=0, pend_target=0, pend_nullify=0, slot_nullify=0, state=SEQ.
- While reset is high: back_le=0, back_d=FRONT_RST+INC.
- Effective branch: eff_taken = br_taken | pend_valid.
  - eff_target = br_taken ? br_target : pend_target.
  - eff_nullify = br_taken ? br_nullify : pend_nullify.
  - A live branch overrides a pending one.
- stall=0:
  - back_le=1, front <= back_q.
  - back_d = eff_taken ? {eff_target[WIDTH-1:2],2'b00} : back_q+INC, modulo 2^WIDTH, so 252+4 wraps to 0.
  - pend_valid <= 0.
  - slot_nullify <= eff_taken & eff_nullify. This applies to the delay slot, which becomes front next cycle.
- stall=1:
  - back_le=0; front and slot_nullify hold.
  - If br_taken: pend_valid<=1 and pend_target/pend_nullify are captured; a later live branch during the same stall overwrites them.
- FSM states: SEQ=00, HELD=01, PEND=10, DELAY=11.
  - SEQ/DELAY: stall & br_taken -> PEND; stall -> HELD; !stall & eff_taken -> DELAY; otherwise -> SEQ.
  - HELD: stall & br_taken -> PEND; stall -> HELD; !stall & br_taken -> DELAY; !stall -> SEQ.
  - PEND: stall -> PEND; !stall -> DELAY.
- A branch in the delay slot is legal: it is taken normally, and a DELAY->DELAY transition results.

## Timing
- back_d and back_le are combinational from stall, br_*, pend_* and back_q. There is no register between this block and the back stage.
- Front update latency is one cycle: the edge after a non-stalled cycle loads front=back_q.
- Redirect latency: a target accepted in cycle N appears on back_q at N+1 and on iaoq_front at N+2. The delay slot is on iaoq_front at N+1.
- A pending branch takes effect in the first cycle with stall=0; no cycle is lost.
- Reset mid-stall or with pend_valid=1: all state clears on the next edge, and the pending branch is discarded.
- reset has priority over stall and br_taken.

## Structure
- Shared package `iaoq_pkg`: the state encodings (SEQ/HELD/PEND/DELAY), IAOQ_INC=4, IAOQ_FRONT_RST=0 and IAOQ_BACK_RST=4. The back stage reset constant moves into this package.
- One natural sub-module: `iaoq_pend_buf`, the one-entry pending-branch buffer (valid/target/nullify, with capture-on-stall and clear-on-advance behaviour).
- The next-address mux and FSM stay in the top module.

## Test plan
- Reset released, no stall, no branches:
  - iaoq_front steps 0,4,8,12.
  - back_d = back_q+4.
  - back_le=1.
  - state=SEQ.
- Sequential wrap: back_q=252, stall=0 -> back_d=0; the next iaoq_front is 252, then 0.
- br_taken with br_target=0x43 at back_q=16, no stall:
  - back_d=0x40.
  - Next cycle: iaoq_front=16 (delay slot), state=DELAY, slot_nullify=0.
  - The cycle after: iaoq_front=0x40.
- Branch during stall: stall=1 for 3 cycles with br_taken=1, target=0x80, nullify=1 in the first cycle.
  - During the stall: back_le=0, front held, state=PEND.
  - On release: back_d=0x80, and the next cycle has slot_nullify=1.
- Two branches in the same stall (targets 0x20 then 0x60) -> on release back_d=0x60.
- Reset asserted while state=PEND -> next cycle iaoq_front=0, pend cleared, state=SEQ, and the stale target is never loaded.

Source files
------------

// File: rtl/iaoq_pkg.sv
// Shared IAOQ definitions.
//   iaoq_state_e   : sequencer FSM state encoding (SEQ/HELD/PEND/DELAY)
//   IAOQ_INC       : sequential increment, one instruction
//   IAOQ_FRONT_RST : front register reset value
//   IAOQ_BACK_RST  : back register reset value (front reset + one instruction)
package iaoq_pkg;

  typedef enum logic [1:0] {
    SEQ   = 2'b00,  // sequential fetch
    HELD  = 2'b01,  // stalled, nothing parked
    PEND  = 2'b10,  // stalled with a branch parked in the pending buffer
    DELAY = 2'b11   // delay slot of a taken branch is at the front
  } iaoq_state_e;

  localparam int unsigned IAOQ_INC       = 4;
  localparam int unsigned IAOQ_FRONT_RST = 0;
  localparam int unsigned IAOQ_BACK_RST  = IAOQ_FRONT_RST + IAOQ_INC;

endpackage

// File: rtl/iaoq_sequencer_if.sv
// Bus between the IAOQ sequencer and its surroundings (pipe control,
// back stage, instruction memory).
//   slave  : the sequencer (consumes stall/branch/back_q, produces addresses)
//   master : the environment driving stall/branch/back_q
interface iaoq_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             br_nullify;
  logic [WIDTH-1:0] back_q;
  logic [WIDTH-1:0] iaoq_front;
  logic [WIDTH-1:0] back_d;
  logic             back_le;
  logic             slot_nullify;
  logic [1:0]       state;

  modport slave (
    input  stall, br_taken, br_target, br_nullify, back_q,
    output iaoq_front, back_d, back_le, slot_nullify, state
  );

  modport master (
    output stall, br_taken, br_target, br_nullify, back_q,
    input  iaoq_front, back_d, back_le, slot_nullify, state
  );
endinterface

// File: rtl/iaoq_pend_buf.sv
// One-entry pending-branch buffer.
// A branch resolved while the pipe is stalled is captured here; a later
// branch in the same stall overwrites it. The entry is dropped on the first
// non-stalled cycle, which is the cycle in which it is consumed.
//   clk, reset              : clock, synchronous active-high reset
//   stall                   : pipe stall
//   br_taken/target/nullify : live branch
//   pend_valid/target/nullify : parked branch
module iaoq_pend_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             br_nullify,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_target,
  output logic             pend_nullify
);

  logic             pend_valid_q,   pend_valid_d;
  logic [WIDTH-1:0] pend_target_q,  pend_target_d;
  logic             pend_nullify_q, pend_nullify_d;

  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_target_d  = pend_target_q;
    pend_nullify_d = pend_nullify_q;
    if (reset) begin
      pend_valid_d   = 1'b0;
      pend_target_d  = '0;
      pend_nullify_d = 1'b0;
    end else if (!stall) begin
      pend_valid_d = 1'b0;
    end else if (br_taken) begin
      pend_valid_d   = 1'b1;
      pend_target_d  = br_target;
      pend_nullify_d = br_nullify;
    end
  end

  always_ff @(posedge clk) begin
    pend_valid_q   <= pend_valid_d;
    pend_target_q  <= pend_target_d;
    pend_nullify_q <= pend_nullify_d;
  end

  assign pend_valid   = pend_valid_q;
  assign pend_target  = pend_target_q;
  assign pend_nullify = pend_nullify_q;

endmodule

// File: rtl/iaoq_sequencer.sv
// IAOQ front-half sequencer. Owns the front (fetch address) register and
// computes the combinational load value/enable for the IAOQ back register,
// including PA-RISC delayed-branch redirection with a one-entry pending
// buffer for branches resolved during a stall.
//   clk, reset : clock, synchronous active-high reset (priority over all)
//   bus.stall, bus.br_taken, bus.br_target, bus.br_nullify, bus.back_q : in
//   bus.iaoq_front, bus.slot_nullify, bus.state : registered outputs
//   bus.back_d, bus.back_le                      : combinational outputs
module iaoq_sequencer
  import iaoq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned INC       = IAOQ_INC,
  parameter int unsigned FRONT_RST = IAOQ_FRONT_RST
) (
  input logic             clk,
  input logic             reset,
  iaoq_sequencer_if.slave bus
);

  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             pend_nullify;

  logic             eff_taken;
  logic [WIDTH-1:0] eff_target;
  logic             eff_nullify;

  logic [WIDTH-1:0] front_q, front_d;
  logic             slot_nullify_q, slot_nullify_d;
  iaoq_state_e      state_q, state_d;
  logic [WIDTH-1:0] back_d;
  logic             back_le;

  iaoq_pend_buf #(.WIDTH(WIDTH)) u_pend_buf (
    .clk          (clk),
    .reset        (reset),
    .stall        (bus.stall),
    .br_taken     (bus.br_taken),
    .br_target    (bus.br_target),
    .br_nullify   (bus.br_nullify),
    .pend_valid   (pend_valid),
    .pend_target  (pend_target),
    .pend_nullify (pend_nullify)
  );

  // A live branch overrides a parked one.
  assign eff_taken   = bus.br_taken | pend_valid;
  assign eff_target  = bus.br_taken ? bus.br_target  : pend_target;
  assign eff_nullify = bus.br_taken ? bus.br_nullify : pend_nullify;

  // Next-address mux for the back stage; the sum wraps modulo 2^WIDTH.
  always_comb begin
    back_le = 1'b0;
    back_d  = WIDTH'(FRONT_RST + INC);
    if (!reset) begin
      back_le = !bus.stall;
      if (eff_taken)
        back_d = eff_target & ~{{(WIDTH-2){1'b0}}, 2'b11};
      else
        back_d = bus.back_q + WIDTH'(INC);
    end
  end

  always_comb begin
    front_d        = front_q;
    slot_nullify_d = slot_nullify_q;
    state_d        = state_q;
    if (reset) begin
      front_d        = WIDTH'(FRONT_RST);
      slot_nullify_d = 1'b0;
      state_d        = SEQ;
    end else begin
      if (!bus.stall) begin
        front_d        = bus.back_q;
        // Marks the delay slot, which is at the front next cycle.
        slot_nullify_d = eff_taken & eff_nullify;
      end
      case (state_q)
        PEND: state_d = bus.stall ? PEND : DELAY;
        HELD: begin
          if (bus.stall)         state_d = bus.br_taken ? PEND : HELD;
          else if (bus.br_taken) state_d = DELAY;
          else                   state_d = SEQ;
        end
        default: begin  // SEQ, DELAY
          if (bus.stall)      state_d = bus.br_taken ? PEND : HELD;
          else if (eff_taken) state_d = DELAY;
          else                state_d = SEQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    front_q        <= front_d;
    slot_nullify_q <= slot_nullify_d;
    state_q        <= state_d;
  end

  assign bus.iaoq_front   = front_q;
  assign bus.slot_nullify = slot_nullify_q;
  assign bus.state        = state_q;
  assign bus.back_d       = back_d;
  assign bus.back_le      = back_le;

endmodule

// File: tb/tb_iaoq_sequencer.sv
// Self-checking bench for iaoq_sequencer: directed scenarios followed by a
// randomized run against a behavioural model of the front/pending/back queue.
module tb_iaoq_sequencer;

  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  iaoq_sequencer_if #(.WIDTH(W)) bus ();

  iaoq_sequencer #(.WIDTH(W), .INC(4), .FRONT_RST(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs away from the rising edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic s, input logic bt,
                       input logic [W-1:0] tg, input logic nl, input logic [W-1:0] bq);
    @(negedge clk);
    reset          = r;
    bus.stall      = s;
    bus.br_taken   = bt;
    bus.br_target  = tg;
    bus.br_nullify = nl;
    bus.back_q     = bq;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 8'h00, 0, 8'h00);
    drive(1, 1, 1, 8'h55, 1, 8'h10);
    checks++; if (bus.back_le !== 1'b0) begin errors++; $display("FAIL reset_back_le: got %0h want 0", bus.back_le); end
    checks++; if (bus.back_d !== 8'd4) begin errors++; $display("FAIL reset_back_d: got %0h want 4", bus.back_d); end
    drive(0, 0, 0, 8'h00, 0, 8'd4);
    checks++; if (bus.iaoq_front !== 8'd0) begin errors++; $display("FAIL reset_front: got %0h want 0", bus.iaoq_front); end
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0h want 0", bus.state); end
    checks++; if (bus.slot_nullify !== 1'b0) begin errors++; $display("FAIL reset_slot_nullify: got %0h want 0", bus.slot_nullify); end
  endtask

  // Continues straight from reset release: back stage holds 4, front 0.
  task automatic test_sequential();
    logic [W-1:0] bq;
    bq = 8'd4;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(0, 0, 0, 8'h00, 0, bq);
      checks++; if (bus.iaoq_front !== W'(4 * i)) begin errors++; $display("FAIL seq_front[%0d]: got %0h want %0h", i, bus.iaoq_front, 4 * i); end
      checks++; if (bus.back_d !== bq + 8'd4) begin errors++; $display("FAIL seq_back_d[%0d]: got %0h want %0h", i, bus.back_d, bq + 8'd4); end
      checks++; if (bus.back_le !== 1'b1) begin errors++; $display("FAIL seq_back_le[%0d]: got %0h want 1", i, bus.back_le); end
      checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL seq_state[%0d]: got %0h want 0", i, bus.state); end
      bq = bq + 8'd4;
    end
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 8'h00, 0, 8'd252);
    checks++; if (bus.back_d !== 8'd0) begin errors++; $display("FAIL wrap_back_d: got %0h want 0", bus.back_d); end
    drive(0, 0, 0, 8'h00, 0, 8'd0);
    checks++; if (bus.iaoq_front !== 8'd252) begin errors++; $display("FAIL wrap_front0: got %0h want fc", bus.iaoq_front); end
    drive(0, 0, 0, 8'h00, 0, 8'd4);
    checks++; if (bus.iaoq_front !== 8'd0) begin errors++; $display("FAIL wrap_front1: got %0h want 0", bus.iaoq_front); end
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 8'h43, 0, 8'd16);
    checks++; if (bus.back_d !== 8'h40) begin errors++; $display("FAIL br_back_d: got %0h want 40", bus.back_d); end
    drive(0, 0, 0, 8'h00, 0, 8'h40);
    checks++; if (bus.iaoq_front !== 8'd16) begin errors++; $display("FAIL br_slot_front: got %0h want 10", bus.iaoq_front); end
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL br_state: got %0h want 3", bus.state); end
    checks++; if (bus.slot_nullify !== 1'b0) begin errors++; $display("FAIL br_slot_nullify: got %0h want 0", bus.slot_nullify); end
    drive(0, 0, 0, 8'h00, 0, 8'h44);
    checks++; if (bus.iaoq_front !== 8'h40) begin errors++; $display("FAIL br_target_front: got %0h want 40", bus.iaoq_front); end
  endtask

  // Front reaches 0x44 at the first edge of this task.
  task automatic test_stall_branch();
    drive(0, 1, 1, 8'h80, 1, 8'h44);
    checks++; if (bus.back_le !== 1'b0) begin errors++; $display("FAIL stall_back_le: got %0h want 0", bus.back_le); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 8'h00, 0, 8'h44);
      checks++; if (bus.iaoq_front !== 8'h44) begin errors++; $display("FAIL stall_front[%0d]: got %0h want 44", i, bus.iaoq_front); end
      checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL stall_state[%0d]: got %0h want 2", i, bus.state); end
      checks++; if (bus.back_le !== 1'b0) begin errors++; $display("FAIL stall_le[%0d]: got %0h want 0", i, bus.back_le); end
    end
    drive(0, 0, 0, 8'h00, 0, 8'h44);
    checks++; if (bus.back_d !== 8'h80) begin errors++; $display("FAIL release_back_d: got %0h want 80", bus.back_d); end
    checks++; if (bus.back_le !== 1'b1) begin errors++; $display("FAIL release_back_le: got %0h want 1", bus.back_le); end
    drive(0, 0, 0, 8'h00, 0, 8'h80);
    checks++; if (bus.slot_nullify !== 1'b1) begin errors++; $display("FAIL release_slot_nullify: got %0h want 1", bus.slot_nullify); end
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL release_state: got %0h want 3", bus.state); end
    drive(0, 0, 0, 8'h00, 0, 8'h84);
    checks++; if (bus.iaoq_front !== 8'h80) begin errors++; $display("FAIL release_front: got %0h want 80", bus.iaoq_front); end
    checks++; if (bus.slot_nullify !== 1'b0) begin errors++; $display("FAIL release_nullify_clr: got %0h want 0", bus.slot_nullify); end
  endtask

  task automatic test_double_branch();
    drive(0, 1, 1, 8'h20, 0, 8'h88);
    drive(0, 1, 1, 8'h60, 0, 8'h88);
    drive(0, 0, 0, 8'h00, 0, 8'h88);
    checks++; if (bus.back_d !== 8'h60) begin errors++; $display("FAIL double_back_d: got %0h want 60", bus.back_d); end
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL double_state: got %0h want 2", bus.state); end
    drive(0, 0, 0, 8'h00, 0, 8'h60);
    checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL double_delay: got %0h want 3", bus.state); end
  endtask

  task automatic test_reset_pend();
    drive(0, 1, 1, 8'h98, 1, 8'h64);
    drive(1, 1, 0, 8'h00, 0, 8'h64);
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL rstp_pend_state: got %0h want 2", bus.state); end
    checks++; if (bus.back_d !== 8'd4) begin errors++; $display("FAIL rstp_back_d: got %0h want 4", bus.back_d); end
    drive(0, 0, 0, 8'h00, 0, 8'd4);
    checks++; if (bus.iaoq_front !== 8'd0) begin errors++; $display("FAIL rstp_front: got %0h want 0", bus.iaoq_front); end
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rstp_state: got %0h want 0", bus.state); end
    checks++; if (bus.back_d !== 8'd8) begin errors++; $display("FAIL rstp_stale: got %0h want 8", bus.back_d); end
    checks++; if (bus.slot_nullify !== 1'b0) begin errors++; $display("FAIL rstp_nullify: got %0h want 0", bus.slot_nullify); end
  endtask

  // Model: fetch address at the front, a parked branch, and the back register
  // the bench itself plays. State is derived from what the pipe is doing:
  // stalled with a parked branch, stalled, just redirected, or sequential.
  task automatic test_random();
    logic [W-1:0] m_front, m_back, m_pt, exp_bd, tgt;
    logic         m_pv, m_pn, m_sn, exp_le, redirect, nul, r, s, bt, nl;
    logic [1:0]   m_state;
    drive(1, 0, 0, 8'h00, 0, 8'h00);
    m_front = 8'd0; m_back = 8'd4; m_pv = 0; m_pt = 8'd0; m_pn = 0; m_sn = 0; m_state = 2'd0;
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 99) < 3);
      s  = ($urandom_range(0, 99) < 40);
      bt = ($urandom_range(0, 99) < 25);
      nl = $urandom_range(0, 1) == 1;
      tgt = W'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 8) m_back = W'($urandom_range(0, 255));
      drive(r, s, bt, tgt, nl, m_back);

      redirect = bt | m_pv;
      nul      = bt ? nl : m_pn;
      exp_le   = !r && !s;
      if (r)             exp_bd = 8'd4;
      else if (redirect) exp_bd = W'(((bt ? tgt : m_pt) / 4) * 4);
      else               exp_bd = W'((int'(m_back) + 4) % 256);

      checks++; if (bus.iaoq_front !== m_front) begin errors++; $display("FAIL rnd_front c=%0d: got %0h want %0h", c, bus.iaoq_front, m_front); end
      checks++; if (bus.slot_nullify !== m_sn) begin errors++; $display("FAIL rnd_nullify c=%0d: got %0h want %0h", c, bus.slot_nullify, m_sn); end
      checks++; if (bus.state !== m_state) begin errors++; $display("FAIL rnd_state c=%0d: got %0h want %0h", c, bus.state, m_state); end
      checks++; if (bus.back_le !== exp_le) begin errors++; $display("FAIL rnd_back_le c=%0d: got %0h want %0h", c, bus.back_le, exp_le); end
      if (r || !s) begin
        checks++; if (bus.back_d !== exp_bd) begin errors++; $display("FAIL rnd_back_d c=%0d: got %0h want %0h", c, bus.back_d, exp_bd); end
      end

      if (r) begin
        m_front = 8'd0; m_back = 8'd4; m_pv = 0; m_pt = 8'd0; m_pn = 0; m_sn = 0; m_state = 2'd0;
      end else if (!s) begin
        m_front = m_back;
        m_back  = exp_bd;
        m_sn    = redirect & nul;
        m_pv    = 0;
        m_state = redirect ? 2'd3 : 2'd0;
      end else begin
        if (bt) begin m_pv = 1; m_pt = tgt; m_pn = nl; end
        m_state = m_pv ? 2'd2 : 2'd1;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.br_nullify = 1'b0; bus.back_q = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_branch();
    test_stall_branch();
    test_double_branch();
    test_reset_pend();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
